// File: rtl/uart_pkg.sv
// Shared types for the parameterised UART receiver.
// UART_RX_BREAK_DET_EN adds the BREAK state to rx_state_e.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE,
      PAR_EVEN,
      PAR_ODD
   } parity_mode_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
`ifdef UART_RX_BREAK_DET_EN
      , BREAK
`endif
   } rx_state_e;

   // Expected parity bit for a zero-extended data word.
   function automatic logic parity_bit(input logic [8:0] d, input parity_mode_e mode);
      return (mode == PAR_ODD) ? ~^d : ^d;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input, reset to RST_VAL.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Double-register the async input to settle metastability.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: start/data/parity/stop decoding with error flags.
// Optional macro UART_RX_BREAK_DET_EN adds break detection and the break_det output.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int unsigned  CLKS_PER_BIT = 16,
   parameter int unsigned  DATA_BITS    = 8,
   parameter parity_mode_e PARITY_MODE  = PAR_NONE,
   parameter int unsigned  STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 RX_in,
   output logic [DATA_BITS-1:0] RX_data_out,
   output logic                 data_ready,
   output logic                 parity_err,
   output logic                 stop_err,
   output logic                 rx_busy
`ifdef UART_RX_BREAK_DET_EN
   ,
   output logic                 break_det
`endif
);

   localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF      = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] LAST      = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
   localparam bit               HAS_PAR   = (PARITY_MODE != PAR_NONE);

   rx_state_e            state;
   logic                 rx_s;
   logic                 rx_prev;
   logic [CNT_W-1:0]     cnt;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 stop_bad;
   logic                 stop_bad_c;
   logic                 exp_par_c;

   uart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (RX_in),
      .q   (rx_s)
   );

   // Stop-error including the sample being taken this cycle, and the expected parity.
   assign stop_bad_c = stop_bad | ~rx_s;
   assign exp_par_c  = parity_bit(9'(shreg), PARITY_MODE);

   // Receive FSM with bit timing, shifting and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rx_prev     <= 1'b1;
         cnt         <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         par_bit     <= 1'b0;
         stop_bad    <= 1'b0;
         RX_data_out <= '0;
         data_ready  <= 1'b0;
         parity_err  <= 1'b0;
         stop_err    <= 1'b0;
         rx_busy     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
         break_det   <= 1'b0;
`endif
      end else begin
         rx_prev    <= rx_s;
         data_ready <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
         break_det  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               // A low line right after data_ready is a start bit that began in the stop bit.
               if (!rx_s && (rx_prev || data_ready)) begin
                  state    <= START;
                  cnt      <= '0;
                  bit_cnt  <= '0;
                  par_bit  <= 1'b0;
                  stop_bad <= 1'b0;
                  rx_busy  <= 1'b1;
               end
            end
            START: begin
               if (cnt == HALF) begin
                  cnt <= '0;
                  if (rx_s) begin
                     state   <= IDLE;
                     rx_busy <= 1'b0;
                  end else begin
                     state <= DATA;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (cnt == LAST) begin
                  cnt   <= '0;
                  shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
                     state   <= HAS_PAR ? PARITY : STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            PARITY: begin
               if (cnt == LAST) begin
                  cnt     <= '0;
                  par_bit <= rx_s;
                  state   <= STOP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (cnt == LAST) begin
                  cnt      <= '0;
                  stop_bad <= stop_bad_c;
`ifdef UART_RX_BREAK_DET_EN
                  if (bit_cnt == 4'd0 && !rx_s && shreg == '0 && !par_bit) begin
                     state     <= BREAK;
                     break_det <= 1'b1;
                  end else
`endif
                  if (bit_cnt == STOP_LAST) begin
                     state       <= IDLE;
                     rx_busy     <= 1'b0;
                     data_ready  <= 1'b1;
                     RX_data_out <= shreg;
                     stop_err    <= stop_bad_c;
                     parity_err  <= HAS_PAR && (par_bit != exp_par_c) && !stop_bad_c;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
`ifdef UART_RX_BREAK_DET_EN
            BREAK: begin
               // Leave only after one full bit period of continuous high line.
               if (!rx_s) begin
                  cnt <= '0;
               end else if (cnt == LAST) begin
                  cnt     <= '0;
                  state   <= IDLE;
                  rx_busy <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
`endif
            default: begin
               state   <= IDLE;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: one 8-bit even-parity instance and one
// 7-bit odd-parity two-stop-bit instance, driven with directed and random frames.
module tb_uart_rx_param;
   import uart_pkg::*;

   localparam int CPB1 = 16;
   localparam int CPB2 = 10;

   typedef struct packed {
      logic [8:0] d;
      logic       pe;
      logic       se;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst1, rst2, rx1, rx2;
   logic [7:0] dout1;
   logic [6:0] dout2;
   logic       dr1, pe1, se1, bz1;
   logic       dr2, pe2, se2, bz2;
`ifdef UART_RX_BREAK_DET_EN
   logic       bd1, bd2;
`endif

   int   checks = 0;
   int   errors = 0;
   int   dr1_cnt = 0;
   int   dr2_cnt = 0;
   logic dr1_q = 1'b0;
   logic dr2_q = 1'b0;
   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;

   always #5 clk = ~clk;

   uart_rx_param #(
      .CLKS_PER_BIT (CPB1),
      .DATA_BITS    (8),
      .PARITY_MODE  (PAR_EVEN),
      .STOP_BITS    (1)
   ) dut1 (
      .clk         (clk),
      .rst         (rst1),
      .RX_in       (rx1),
      .RX_data_out (dout1),
      .data_ready  (dr1),
      .parity_err  (pe1),
      .stop_err    (se1),
      .rx_busy     (bz1)
`ifdef UART_RX_BREAK_DET_EN
      ,
      .break_det   (bd1)
`endif
   );

   uart_rx_param #(
      .CLKS_PER_BIT (CPB2),
      .DATA_BITS    (7),
      .PARITY_MODE  (PAR_ODD),
      .STOP_BITS    (2)
   ) dut2 (
      .clk         (clk),
      .rst         (rst2),
      .RX_in       (rx2),
      .RX_data_out (dout2),
      .data_ready  (dr2),
      .parity_err  (pe2),
      .stop_err    (se2),
      .rx_busy     (bz2)
`ifdef UART_RX_BREAK_DET_EN
      ,
      .break_det   (bd2)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input int inst, input logic v, input int n);
      if (inst == 0) rx1 = v;
      else           rx2 = v;
      repeat (n) @(negedge clk);
   endtask

   // Send one frame; the expectation is derived from the frame content alone.
   task automatic send_frame(input int inst, input logic [8:0] d, input bit flip,
                             input logic [1:0] stop_low, input int gap);
      int         nb, cpb, ns;
      logic [8:0] dm;
      logic [1:0] sl;
      logic       par;
      bit         brk;
      exp_t       e;
      nb  = (inst == 0) ? 8 : 7;
      cpb = (inst == 0) ? CPB1 : CPB2;
      ns  = (inst == 0) ? 1 : 2;
      dm  = d & 9'((1 << nb) - 1);
      sl  = (ns == 2) ? stop_low : (stop_low & 2'b01);
      par = ($countones(dm) % 2) == 1;
      if (inst == 1) par = !par;
      par = par ^ flip;
      e.d  = dm;
      e.se = (sl != 2'b00);
      e.pe = flip && !e.se;
      brk  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk = (dm == 9'd0) && !par && sl[0];
`endif
      if (!brk) begin
         if (inst == 0) q1.push_back(e);
         else           q2.push_back(e);
      end
      drive(inst, 1'b0, cpb);
      check("busy_in_frame", 32'((inst == 0) ? bz1 : bz2), 32'd1);
      for (int i = 0; i < nb; i++) drive(inst, dm[i], cpb);
      drive(inst, par, cpb);
      for (int s = 0; s < ns; s++) drive(inst, !sl[s], cpb);
      drive(inst, 1'b1, gap);
   endtask

   // Monitor for instance 1.
   always @(negedge clk) begin
      dr1_q <= dr1;
      if (dr1) begin
         dr1_cnt <= dr1_cnt + 1;
         check("dr1_width", 32'(dr1_q), 32'd0);
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dr1_unexpected: data %0h, none expected", dout1);
         end else begin
            e1 = q1.pop_front();
            check("dout1", 32'(dout1), 32'(e1.d));
            check("perr1", 32'(pe1), 32'(e1.pe));
            check("serr1", 32'(se1), 32'(e1.se));
         end
      end
   end

   // Monitor for instance 2.
   always @(negedge clk) begin
      dr2_q <= dr2;
      if (dr2) begin
         dr2_cnt <= dr2_cnt + 1;
         check("dr2_width", 32'(dr2_q), 32'd0);
         if (q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dr2_unexpected: data %0h, none expected", dout2);
         end else begin
            e2 = q2.pop_front();
            check("dout2", 32'(dout2), 32'(e2.d));
            check("perr2", 32'(pe2), 32'(e2.pe));
            check("serr2", 32'(se2), 32'(e2.se));
         end
      end
   end

   initial begin
      int         snap;
      logic [8:0] d;
      bit         flip;
      logic [1:0] sl;
      int         gap;

      rst1 = 1'b1; rst2 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_dout1", 32'(dout1), 32'd0);
      check("rst_dr1",   32'(dr1),   32'd0);
      check("rst_pe1",   32'(pe1),   32'd0);
      check("rst_se1",   32'(se1),   32'd0);
      check("rst_busy1", 32'(bz1),   32'd0);
      check("rst_dout2", 32'(dout2), 32'd0);
      check("rst_busy2", 32'(bz2),   32'd0);
      rst1 = 1'b0; rst2 = 1'b0;
      repeat (20) @(negedge clk);
      check("idle_busy1", 32'(bz1), 32'd0);

      // Directed frames on instance 1.
      send_frame(0, 9'h0A5, 1'b0, 2'b00, 2 * CPB1);
      check("busy_after_a5", 32'(bz1), 32'd0);
      send_frame(0, 9'h03C, 1'b1, 2'b00, 2 * CPB1);
      send_frame(0, 9'h055, 1'b0, 2'b01, 2 * CPB1);

      // Short low glitch: false start, outputs hold.
      snap = dr1_cnt;
      drive(0, 1'b0, 5);
      drive(0, 1'b1, 4 * CPB1);
      check("glitch_no_dr",  32'(dr1_cnt - snap), 32'd0);
      check("glitch_dout",   32'(dout1), 32'h55);
      check("glitch_se",     32'(se1), 32'd1);
      check("glitch_pe",     32'(pe1), 32'd0);
      check("glitch_busy",   32'(bz1), 32'd0);

      // Reset during bit 4 of 0xFF, then a clean 0x12.
      snap = dr1_cnt;
      drive(0, 1'b0, CPB1);
      for (int i = 0; i < 4; i++) drive(0, 1'b1, CPB1);
      drive(0, 1'b1, CPB1 / 2);
      rst1 = 1'b1;
      repeat (2) @(negedge clk);
      rst1 = 1'b0;
      check("abort_dout", 32'(dout1), 32'd0);
      check("abort_busy", 32'(bz1), 32'd0);
      drive(0, 1'b1, 3 * CPB1);
      send_frame(0, 9'h012, 1'b0, 2'b00, CPB1);
      check("abort_one_dr", 32'(dr1_cnt - snap), 32'd1);

      // Random frames on instance 1.
      for (int i = 0; i < 40; i++) begin
         d    = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(0, 255));
         flip = ($urandom_range(0, 3) == 0);
         sl   = ($urandom_range(0, 5) == 0) ? 2'b01 : 2'b00;
         gap  = (sl != 2'b00) ? 2 * CPB1 : 32'($urandom_range(0, 3)) * (CPB1 / 2);
         send_frame(0, d, flip, sl, gap);
      end

      // Back-to-back 0x41, 0x7F on instance 2.
      snap = dr2_cnt;
      send_frame(1, 9'h041, 1'b0, 2'b00, 0);
      send_frame(1, 9'h07F, 1'b0, 2'b00, CPB2);
      check("b2b_two_dr", 32'(dr2_cnt - snap), 32'd2);

      // Random frames on instance 2.
      for (int i = 0; i < 30; i++) begin
         d    = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(0, 127));
         flip = ($urandom_range(0, 3) == 0);
         sl   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         gap  = (sl != 2'b00) ? 2 * CPB2 : 32'($urandom_range(0, 2)) * (CPB2 / 2);
         send_frame(1, d, flip, sl, gap);
      end

      repeat (60) @(negedge clk);
      check("q1_drained", 32'(q1.size()), 32'd0);
      check("q2_drained", 32'(q2.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; the ports are named clk and rst.
REQ-002 Parameter CLKS_PER_BIT, default 16, SHALL set clk cycles per UART bit; legal range 4..65535.
REQ-003 Parameter DATA_BITS, default 8, SHALL set data bits per frame; legal range 5..9.
REQ-004 Parameter PARITY_MODE, default PAR_NONE, SHALL select parity: PAR_NONE, PAR_EVEN or PAR_ODD.
REQ-005 Parameter STOP_BITS, default 1, SHALL set stop bits per frame; legal values 1 or 2.
REQ-006 clk  input  1  system clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 RX_in  input  1  asynchronous serial line; idles high.
REQ-009 RX_data_out  output  DATA_BITS  last received word, LSB first on the line.
REQ-010 data_ready  output  1  one-cycle pulse when a frame completes.
REQ-011 parity_err  output  1  parity mismatch on the last frame.
REQ-012 stop_err  output  1  a stop bit was sampled low on the last frame.
REQ-013 rx_busy  output  1  high in every state except IDLE.

Function
REQ-014 RX_in SHALL pass through a 2-flop synchroniser, reset to 1; all decoding SHALL use the synchronised line.
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, plus BREAK when the break feature is compiled in.
REQ-016 IDLE SHALL move to START on a synchronised high-to-low edge and clear the bit counter.
REQ-017 START SHALL sample at cycle CLKS_PER_BIT/2 (integer division); low -> DATA, high -> IDLE (false start, no flags, no data_ready).
REQ-018 DATA, PARITY and STOP SHALL each sample once every CLKS_PER_BIT cycles after the start-bit midpoint.
REQ-019 DATA SHALL shift in DATA_BITS samples LSB first, then go to PARITY, or to STOP when PARITY_MODE = PAR_NONE.
REQ-020 The expected parity bit SHALL be the XOR of the data bits for PAR_EVEN and its inverse for PAR_ODD.
REQ-021 STOP SHALL sample STOP_BITS bits; any low sample sets the internal stop-error flag.
REQ-022 After the last stop sample, on the next clk: RX_data_out, parity_err and stop_err SHALL update, data_ready SHALL pulse for exactly 1 cycle, and the FSM SHALL return to IDLE.
REQ-023 If a stop error occurs, stop_err SHALL be 1 and parity_err SHALL be forced to 0, so the two are never high together.
REQ-024 RX_data_out, parity_err and stop_err SHALL hold their values until the next data_ready; they SHALL NOT change on a false start.
REQ-025 A low line seen in IDLE in the cycle immediately after data_ready SHALL start a new frame with no lost cycles.
REQ-026 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide and wrap to 0 at CLKS_PER_BIT-1.

Reset
REQ-027 While rst = 1, on each clk: state = IDLE; counters = 0; RX_data_out = 0; data_ready = parity_err = stop_err = rx_busy = 0; synchroniser = 1.
REQ-028 An rst assertion mid-frame SHALL abort the frame with no data_ready pulse; after release the FSM SHALL wait for a new falling edge.

Configuration
REQ-029 Macro UART_RX_BREAK_DET_EN, when defined, SHALL add output break_det (1 bit, reset 0).
REQ-030 With the macro defined: an all-zero data field, a zero parity bit (if any) and a low first stop bit SHALL enter BREAK instead of pulsing data_ready.
REQ-031 In BREAK, break_det SHALL pulse for 1 cycle on entry; the FSM SHALL return to IDLE only after the line has been high for one full CLKS_PER_BIT period.
REQ-032 Without the macro, no break_det port SHALL exist, and that frame SHALL be reported as a normal frame with stop_err = 1 and RX_data_out = 0.

Structure
REQ-033 Package uart_pkg SHALL hold the parity_mode_e enum (PAR_NONE, PAR_EVEN, PAR_ODD) and the rx_state_e enum.
REQ-034 Sub-module uart_sync2 SHALL implement the 2-flop synchroniser with a parameterised reset value.

Verification (CLKS_PER_BIT = 16, DATA_BITS = 8, PAR_EVEN, STOP_BITS = 1 unless stated)
REQ-035 Frame 0xA5 with correct parity -> one data_ready pulse, RX_data_out = 8'hA5, parity_err = 0, stop_err = 0.
REQ-036 Frame 0x3C with parity bit inverted -> data_ready pulse, RX_data_out = 8'h3C, parity_err = 1, stop_err = 0.
REQ-037 Frame 0x55 with the stop bit driven low (macro off) -> stop_err = 1, parity_err = 0.
REQ-038 Low glitch of 5 cycles in IDLE -> no data_ready; RX_data_out keeps its previous value.
REQ-039 rst pulsed during bit 4 of frame 0xFF, then frame 0x12 sent -> exactly one data_ready, with RX_data_out = 8'h12.
REQ-040 DATA_BITS = 7, PAR_ODD, STOP_BITS = 2, back-to-back frames 0x41 and 0x7F -> two data_ready pulses, with no errors.
